// File: rtl/anim_sequencer.sv
// Animation frame sequencer.
// A tick counter divides clk down to the frame rate and steps a frame index
// in loop, one-shot, ping-pong or reverse-loop order. Playback can be started,
// restarted and paused. The current frame and the display's pixel coordinates
// go straight out to an external frame memory, and the returned word is
// registered as the output pixel.
module anim_sequencer #(
  parameter int FRAMES   = 16,
  parameter int FRAME_W  = 4,
  parameter int TICK_DIV = 33554432,
  parameter int DIV_W    = 26,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr_x,
  input  logic [ADDR_W-1:0] addr_y,
  output logic [FRAME_W-1:0] mem_frame,
  output logic [ADDR_W-1:0] mem_addr_x,
  output logic [ADDR_W-1:0] mem_addr_y,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] pix_data,
  output logic [FRAME_W-1:0] frame,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] MODE_LOOP    = 2'b00;
  localparam logic [1:0] MODE_ONESHOT = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_REVERSE = 2'b11;

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES - 1);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_ZERO = '0;
  localparam logic [DIV_W-1:0]   TICK_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0]   TICK_ONE   = DIV_W'(1);

  state_e             state_q;
  logic [1:0]         mode_q;
  logic [FRAME_W-1:0] frame_q;
  logic [DIV_W-1:0]   tick_q;
  logic               dir_q;
  logic               done_q;
  logic [DATA_W-1:0]  pix_q;

  logic [FRAME_W-1:0] frame_d;
  logic               dir_d;
  logic               oneshot_end;

  // Work out where the frame index goes at the next terminal tick.
  // dir_q=1 means counting up; a lone frame in ping-pong never moves.
  always_comb begin
    frame_d     = frame_q;
    dir_d       = dir_q;
    oneshot_end = 1'b0;
    case (mode_q)
      MODE_LOOP: begin
        frame_d = (frame_q == FRAME_LAST) ? FRAME_ZERO : frame_q + FRAME_ONE;
      end
      MODE_ONESHOT: begin
        if (frame_q == FRAME_LAST) begin
          oneshot_end = 1'b1;
        end else begin
          frame_d = frame_q + FRAME_ONE;
        end
      end
      MODE_PINGPONG: begin
        if (FRAMES > 1) begin
          if (dir_q) begin
            if (frame_q == FRAME_LAST) begin
              frame_d = FRAME_LAST - FRAME_ONE;
              dir_d   = 1'b0;
            end else begin
              frame_d = frame_q + FRAME_ONE;
            end
          end else begin
            if (frame_q == FRAME_ZERO) begin
              frame_d = FRAME_ONE;
              dir_d   = 1'b1;
            end else begin
              frame_d = frame_q - FRAME_ONE;
            end
          end
        end
      end
      MODE_REVERSE: begin
        frame_d = (frame_q == FRAME_ZERO) ? FRAME_LAST : frame_q - FRAME_ONE;
      end
      default: begin
        frame_d = frame_q;
      end
    endcase
  end

  // Playback state machine: start always wins, a paused cycle neither counts
  // nor advances, and the cycle that leaves pause counts as a normal tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_LOOP;
      frame_q <= '0;
      tick_q  <= '0;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q <= S_PLAY;
        mode_q  <= mode;
        tick_q  <= '0;
        frame_q <= (mode == MODE_REVERSE) ? FRAME_LAST : FRAME_ZERO;
        dir_q   <= 1'b1;
      end else begin
        case (state_q)
          S_PLAY, S_PAUSED: begin
            if (pause) begin
              state_q <= S_PAUSED;
            end else begin
              state_q <= S_PLAY;
              if (tick_q == TICK_LAST) begin
                tick_q <= '0;
                if (oneshot_end) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end else begin
                  frame_q <= frame_d;
                  dir_q   <= dir_d;
                end
              end else begin
                tick_q <= tick_q + TICK_ONE;
              end
            end
          end
          default: begin
            state_q <= state_q;
          end
        endcase
      end
    end
  end

  // Register the frame-memory word every cycle, whatever the playback state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_q <= '0;
    end else begin
      pix_q <= mem_data;
    end
  end

  assign mem_frame  = frame_q;
  assign mem_addr_x = addr_x;
  assign mem_addr_y = addr_y;
  assign pix_data   = pix_q;
  assign frame      = frame_q;
  assign busy       = (state_q == S_PLAY) || (state_q == S_PAUSED);
  assign done       = done_q;

endmodule
